new_dma: RTL and testbench

//  Custom-instruction (CI) programmed DMA master. The CPU writes configuration registers and a
//  512x32 local buffer through the CI port. A control write then launches burst transfers

---
 rtl/new_dma_pkg.sv | 16 +
 rtl/new_dma_if.sv | 29 ++
 rtl/new_dma_buffer_ram.sv | 19 +
 rtl/new_dma.sv | 127 ++++++++++++
 tb/tb_new_dma.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/new_dma_pkg.sv
// new_dma_pkg: register map, control codes and FSM states shared by the DMA block
package new_dma_pkg;
  localparam logic [7:0] CUSTOM_ID = 8'd12;
  localparam logic [2:0] REG_BUF = 3'd0;
  localparam logic [2:0] REG_BUS_ADDR = 3'd1;
  localparam logic [2:0] REG_MEM_ADDR = 3'd2;
  localparam logic [2:0] REG_BLOCK = 3'd3;
  localparam logic [2:0] REG_BURST = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;
  localparam logic [1:0] CTRL_READ = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;
  typedef enum logic [2:0] {ST_IDLE, ST_REQUEST, ST_BEGIN, ST_DATA, ST_END} state_e;
  function automatic logic [7:0] burst_len(input logic [9:0] remaining, input logic [7:0] burst);
    return (remaining < {2'b00, burst}) ? remaining[7:0] : burst;
  endfunction
endpackage

// File: rtl/new_dma_if.sv
// new_dma_if: CI port plus system bus signals of the DMA master
interface new_dma_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        bus_aquire;
  logic        bus_error;
  logic        slave_busy;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_begin;
  logic        in_end;
  logic [31:0] address_data;
  logic [3:0]  BE;
  logic        bus_request;
  logic        begin_transaction;
  logic        data_valid;
  logic        end_transaction;
  logic        busy;
  modport master (
    input  start, ciN, valueA, valueB, bus_aquire, bus_error, slave_busy, in_valid, in_data, in_begin, in_end,
    output address_data, BE, bus_request, begin_transaction, data_valid, end_transaction, busy
  );
  modport slave (
    output start, ciN, valueA, valueB, bus_aquire, bus_error, slave_busy, in_valid, in_data, in_begin, in_end,
    input  address_data, BE, bus_request, begin_transaction, data_valid, end_transaction, busy
  );
endinterface

// File: rtl/new_dma_buffer_ram.sv
// dma_buffer_ram: 512x32 buffer, CI write port, DMA write port and registered DMA read port
module dma_buffer_ram (
  input  logic        clock,
  input  logic        a_we,
  input  logic [8:0]  a_addr,
  input  logic [31:0] a_wdata,
  input  logic        b_we,
  input  logic [8:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic [8:0]  r_addr,
  output logic [31:0] r_data
);
  logic [31:0] mem [512];
  always_ff @(posedge clock) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    r_data <= mem[r_addr];
  end
endmodule

// File: rtl/new_dma.sv
// new_dma: CI-programmed burst DMA master moving data between a local buffer and the system bus
module new_dma
  import new_dma_pkg::*;
#(
  parameter logic [7:0] customId = CUSTOM_ID
) (
  input  logic clock,
  input  logic reset,
  new_dma_if.master bus
);
  state_e      state_q, state_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [9:0]  block_size_q, block_size_d;
  logic [7:0]  burst_size_q, burst_size_d;
  logic [1:0]  control_q, control_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rd_data;
  logic        cfg_we, launch, wr_mode, accept, last;
  logic [2:0]  sel;
  logic        unused_bits;
  assign unused_bits = ^{bus.valueA[31:13], bus.in_begin};
  assign sel = bus.valueA[12:10];
  assign cfg_we = bus.ciN == customId && bus.valueA[9];
  assign launch = cfg_we && sel == REG_CTRL && state_q == ST_IDLE && block_size_q != '0 &&
                  (bus.valueB[1:0] == CTRL_READ || bus.valueB[1:0] == CTRL_WRITE);
  assign wr_mode = control_q == CTRL_WRITE;
  assign accept = state_q == ST_DATA && (wr_mode ? !bus.slave_busy : bus.in_valid);
  assign last = cnt_q + 8'd1 == len_q;
  always_comb begin
    state_d = state_q;
    bus_addr_d = bus_addr_q;
    mem_addr_d = mem_addr_q;
    block_size_d = block_size_q;
    burst_size_d = burst_size_q;
    control_d = control_q;
    remaining_d = remaining_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (cfg_we && sel == REG_BUS_ADDR) bus_addr_d = bus.valueB;
    if (cfg_we && sel == REG_MEM_ADDR) mem_addr_d = bus.valueB[8:0];
    if (cfg_we && sel == REG_BLOCK) block_size_d = bus.valueB[9:0];
    if (cfg_we && sel == REG_BURST) burst_size_d = bus.valueB[7:0] == '0 ? 8'd1 : bus.valueB[7:0];
    if (launch) begin
      control_d = bus.valueB[1:0];
      remaining_d = block_size_q;
      state_d = ST_REQUEST;
    end
    unique case (state_q)
      ST_IDLE: if (bus.start) err_d = 1'b0;
      ST_REQUEST: if (bus.bus_aquire) state_d = ST_BEGIN;
      ST_BEGIN: begin
        len_d = burst_len(remaining_q, burst_size_q);
        cnt_d = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          mem_addr_d = mem_addr_q + 9'd1;
          bus_addr_d = bus_addr_q + 32'd4;
          remaining_d = remaining_q - 10'd1;
          cnt_d = cnt_q + 8'd1;
        end
        if ((accept && last) || (!wr_mode && bus.in_end)) state_d = ST_END;
      end
      ST_END: begin
        state_d = remaining_q != '0 ? ST_REQUEST : ST_IDLE;
        control_d = remaining_q != '0 ? control_q : 2'b00;
      end
      default: state_d = ST_IDLE;
    endcase
    // an error abandons the block outright; the CPU must relaunch
    if (state_q != ST_IDLE && bus.bus_error) begin
      state_d = ST_IDLE;
      control_d = 2'b00;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bus_addr_q <= '0;
      mem_addr_q <= '0;
      block_size_q <= '0;
      burst_size_q <= '0;
      control_q <= '0;
      remaining_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_addr_q <= bus_addr_d;
      mem_addr_q <= mem_addr_d;
      block_size_q <= block_size_d;
      burst_size_q <= burst_size_d;
      control_q <= control_d;
      remaining_q <= remaining_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // reading at the next address keeps buffer[memAddr] ready on the first data cycle
  dma_buffer_ram u_ram (
    .clock  (clock),
    .a_we   (cfg_we && sel == REG_BUF),
    .a_addr (bus.valueA[8:0]),
    .a_wdata(bus.valueB),
    .b_we   (accept && !wr_mode),
    .b_addr (mem_addr_q),
    .b_wdata(bus.in_data),
    .r_addr (mem_addr_d),
    .r_data (rd_data)
  );
  assign bus.bus_request = state_q == ST_REQUEST || state_q == ST_BEGIN || state_q == ST_DATA;
  assign bus.begin_transaction = state_q == ST_BEGIN;
  assign bus.data_valid = state_q == ST_DATA && wr_mode;
  assign bus.end_transaction = state_q == ST_END && wr_mode;
  assign bus.BE = (bus.begin_transaction || bus.data_valid) ? 4'hF : 4'h0;
  assign bus.address_data = bus.begin_transaction ? bus_addr_q : bus.data_valid ? rd_data : 32'h0;
  assign bus.busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_new_dma.sv
// tb_new_dma: directed scenario checks of the new_dma DMA master
module tb_new_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  new_dma_if bus();
  new_dma dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ci(input logic [7:0] id, input logic [2:0] sel, input logic [8:0] a, input logic [31:0] b);
    bus.ciN = id;
    bus.valueA = {19'b0, sel, 1'b1, a};
    bus.valueB = b;
    tick();
    bus.ciN = 8'd0;
    bus.valueA = '0;
    bus.valueB = '0;
  endtask

  task automatic grant();
    bus.bus_aquire = 1'b1;
    tick();
    bus.bus_aquire = 1'b0;
  endtask

  task automatic test_reset();
    {bus.start, bus.ciN, bus.valueA, bus.valueB, bus.bus_aquire, bus.bus_error} = '0;
    {bus.slave_busy, bus.in_valid, bus.in_data, bus.in_begin, bus.in_end} = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", bus.busy); end
    n_chk++; if (bus.bus_request !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h want 0", bus.bus_request); end
    n_chk++; if ({bus.begin_transaction, bus.data_valid, bus.end_transaction} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {bus.begin_transaction, bus.data_valid, bus.end_transaction}); end
    n_chk++; if ({bus.BE, bus.address_data} !== 36'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h want 0/0", bus.BE, bus.address_data); end
  endtask

  task automatic test_read_launch();
    ci(8'd12, 3'd1, 9'd0, 32'h0000_1000);
    ci(8'd12, 3'd2, 9'd0, 32'h10);
    ci(8'd12, 3'd3, 9'd0, 32'd12);
    ci(8'd12, 3'd4, 9'd0, 32'd3);
    ci(8'd12, 3'd5, 9'd0, 32'd1);
    n_chk++; if (bus.bus_request !== 1'b1) begin n_fail++; $display("FAIL launch_req got %0h want 1", bus.bus_request); end
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL launch_busy got %0h want 1", bus.busy); end
    tick();
    tick();
    n_chk++; if (bus.begin_transaction !== 1'b0) begin n_fail++; $display("FAIL no_grant_begin got %0h want 0", bus.begin_transaction); end
    n_chk++; if (bus.bus_request !== 1'b1) begin n_fail++; $display("FAIL wait_req got %0h want 1", bus.bus_request); end
  endtask

  task automatic test_read_bursts();
    for (int b = 0; b < 4; b++) begin
      grant();
      n_chk++; if (bus.begin_transaction !== 1'b1) begin n_fail++; $display("FAIL rd_begin%0d got %0h want 1", b, bus.begin_transaction); end
      n_chk++; if (bus.address_data !== 32'h1000 + 32'(12 * b)) begin n_fail++; $display("FAIL rd_addr%0d got %h want %h", b, bus.address_data, 32'h1000 + 32'(12 * b)); end
      n_chk++; if (bus.BE !== 4'hF) begin n_fail++; $display("FAIL rd_be%0d got %h want f", b, bus.BE); end
      tick();
      n_chk++; if ({bus.begin_transaction, bus.data_valid} !== 2'b00) begin n_fail++; $display("FAIL rd_data_strobes%0d got %b want 00", b, {bus.begin_transaction, bus.data_valid}); end
      for (int w = 0; w < 3; w++) begin
        bus.in_valid = 1'b1;
        bus.in_data = 32'hA000_0000 + 32'(3 * b + w);
        tick();
      end
      bus.in_valid = 1'b0;
      n_chk++; if ({bus.bus_request, bus.end_transaction} !== 2'b00) begin n_fail++; $display("FAIL rd_end%0d got %b want 00", b, {bus.bus_request, bus.end_transaction}); end
      tick();
      if (b < 3) begin
        n_chk++; if (bus.bus_request !== 1'b1) begin n_fail++; $display("FAIL rd_rereq%0d got %0h want 1", b, bus.bus_request); end
      end else begin
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_done_busy got %0h want 0", bus.busy); end
      end
    end
  endtask

  task automatic test_write_stall();
    ci(8'd12, 3'd1, 9'd0, 32'h0000_2000);
    ci(8'd12, 3'd2, 9'd0, 32'h10);
    ci(8'd12, 3'd3, 9'd0, 32'd4);
    ci(8'd12, 3'd4, 9'd0, 32'd2);
    ci(8'd12, 3'd5, 9'd0, 32'd2);
    grant();
    n_chk++; if (bus.address_data !== 32'h2000) begin n_fail++; $display("FAIL wr_addr0 got %h want 2000", bus.address_data); end
    tick();
    n_chk++; if ({bus.data_valid, bus.BE} !== 5'h1F) begin n_fail++; $display("FAIL wr_dv got %h want 1f", {bus.data_valid, bus.BE}); end
    n_chk++; if (bus.address_data !== 32'hA000_0000) begin n_fail++; $display("FAIL wr_w0 got %h want a0000000", bus.address_data); end
    tick();
    n_chk++; if (bus.address_data !== 32'hA000_0001) begin n_fail++; $display("FAIL wr_w1 got %h want a0000001", bus.address_data); end
    bus.slave_busy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      n_chk++; if ({bus.data_valid, bus.address_data} !== {1'b1, 32'hA000_0001}) begin n_fail++; $display("FAIL wr_stall%0d got %h want 1a0000001", s, {bus.data_valid, bus.address_data}); end
    end
    bus.slave_busy = 1'b0;
    tick();
    n_chk++; if ({bus.end_transaction, bus.data_valid} !== 2'b10) begin n_fail++; $display("FAIL wr_end0 got %b want 10", {bus.end_transaction, bus.data_valid}); end
    tick();
    grant();
    n_chk++; if (bus.address_data !== 32'h2008) begin n_fail++; $display("FAIL wr_addr1 got %h want 2008", bus.address_data); end
    tick();
    n_chk++; if (bus.address_data !== 32'hA000_0002) begin n_fail++; $display("FAIL wr_w2 got %h want a0000002", bus.address_data); end
    tick();
    n_chk++; if (bus.address_data !== 32'hA000_0003) begin n_fail++; $display("FAIL wr_w3 got %h want a0000003", bus.address_data); end
    tick();
    n_chk++; if (bus.end_transaction !== 1'b1) begin n_fail++; $display("FAIL wr_end1 got %0h want 1", bus.end_transaction); end
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_done_busy got %0h want 0", bus.busy); end
    ci(8'd12, 3'd0, 9'h14, 32'hCAFE_0004);
    ci(8'd12, 3'd3, 9'd0, 32'd1);
    ci(8'd12, 3'd5, 9'd0, 32'd2);
    grant();
    n_chk++; if (bus.address_data !== 32'h2010) begin n_fail++; $display("FAIL wr_addr_total got %h want 2010", bus.address_data); end
    tick();
    n_chk++; if (bus.address_data !== 32'hCAFE_0004) begin n_fail++; $display("FAIL ci_buf_word got %h want cafe0004", bus.address_data); end
    tick();
    tick();
  endtask

  task automatic test_bus_error();
    ci(8'd12, 3'd1, 9'd0, 32'h0000_3000);
    ci(8'd12, 3'd2, 9'd0, 32'h40);
    ci(8'd12, 3'd3, 9'd0, 32'd4);
    ci(8'd12, 3'd4, 9'd0, 32'd4);
    ci(8'd12, 3'd5, 9'd0, 32'd1);
    grant();
    tick();
    for (int w = 0; w < 2; w++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'hE5E5_0001 + 32'(w);
      tick();
    end
    bus.in_valid = 1'b0;
    n_chk++; if (bus.bus_request !== 1'b1) begin n_fail++; $display("FAIL err_pre_req got %0h want 1", bus.bus_request); end
    bus.bus_error = 1'b1;
    tick();
    bus.bus_error = 1'b0;
    n_chk++; if ({bus.bus_request, bus.begin_transaction, bus.data_valid, bus.end_transaction, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL err_ctrl got %b want 00000", {bus.bus_request, bus.begin_transaction, bus.data_valid, bus.end_transaction, bus.busy}); end
    n_chk++; if ({bus.BE, bus.address_data} !== 36'h0) begin n_fail++; $display("FAIL err_bus got %h/%h want 0/0", bus.BE, bus.address_data); end
    tick();
    n_chk++; if (bus.bus_request !== 1'b0) begin n_fail++; $display("FAIL err_idle_req got %0h want 0", bus.bus_request); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_foreign_id();
    ci(8'd12, 3'd0, 9'h42, 32'hBEEF_0042);
    ci(8'd5, 3'd0, 9'h42, 32'hDEAD_0042);
    ci(8'd5, 3'd1, 9'd0, 32'h0000_5000);
    ci(8'd5, 3'd2, 9'd0, 32'h55);
    ci(8'd5, 3'd3, 9'd0, 32'd0);
    ci(8'd5, 3'd5, 9'd0, 32'd2);
    n_chk++; if ({bus.bus_request, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL foreign_ctrl got %b want 00", {bus.bus_request, bus.busy}); end
    ci(8'd12, 3'd3, 9'd0, 32'd1);
    ci(8'd12, 3'd5, 9'd0, 32'd2);
    n_chk++; if (bus.bus_request !== 1'b1) begin n_fail++; $display("FAIL own_ctrl got %0h want 1", bus.bus_request); end
    grant();
    n_chk++; if (bus.address_data !== 32'h3008) begin n_fail++; $display("FAIL foreign_busaddr got %h want 3008", bus.address_data); end
    tick();
    n_chk++; if (bus.address_data !== 32'hBEEF_0042) begin n_fail++; $display("FAIL foreign_buf got %h want beef0042", bus.address_data); end
    tick();
    n_chk++; if (bus.end_transaction !== 1'b1) begin n_fail++; $display("FAIL foreign_end got %0h want 1", bus.end_transaction); end
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL foreign_done got %0h want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_read_launch();
    test_read_bursts();
    test_write_stall();
    test_bus_error();
    test_foreign_id();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
